jts18_vdp_mixctl: RTL
=====================

# jts18_vdp_mixctl

Control block for the System 18 VDP/tilemap priority mixer. It holds the CPU-written mixer control byte in a shadow register, commits it to the live `vdp_prio`/`vdp_en` outputs only at a line or frame boundary so that priority never changes mid-scanline, and runs a watchdog on the VDP horizontal sync that gates the VDP layer off when the VDP stops producing lines. Its outputs drive the priority mixer's `vdp_prio` input and the VDP layer enable.

## Interface
Parameters:
- `WDOG_LINES`, 4: number of host lines without a VDP hsync before `vdp_ok` drops; valid range 1–15.

Ports:
- `rst`  in  1  reset, asynchronous, active-high
- `clk`  in  1  system clock
- `cpu_we`  in  1  one-cycle write strobe for the mixer control byte
- `cpu_din`  in  8  write data: [2:0] priority, [3] VDP enable, [4] commit mode (0 = line, 1 = frame), [7:5] ignored
- `LHBL`  in  1  host horizontal blank, active low
- `LVBL`  in  1  host vertical blank, active low
- `vdp_hs`  in  1  VDP horizontal sync pulse, high for one or more `clk` cycles
- `debug_bus`  in  8  bit 7 set forces `vdp_prio = debug_bus[2:0]`
- `vdp_prio`  out  3  live priority code to the mixer
- `vdp_en`  out  1  live VDP enable, already gated by `vdp_ok`
- `pending`  out  1  shadow register holds an uncommitted value
- `commit`  out  1  one-cycle pulse when the live registers load
- `vdp_ok`  out  1  VDP hsync seen within the last `WDOG_LINES` lines

## Operation
- **Shadow register:** `sh_prio[2:0]`, `sh_en`, `sh_mode`. On `cpu_we` all three load from `cpu_din`. Writes are never dropped; a later write overwrites an earlier pending one.
- **Live registers:** `act_prio`, `act_en`. `vdp_prio = debug_bus[7] ? debug_bus[2:0] : act_prio`. The debug override is combinational and does not alter `act_prio`. `vdp_en = act_en & vdp_ok`.
- **Boundary detect:** `lhbl_l` and `lvbl_l` are registered copies of `LHBL` and `LVBL`.
  - `hb_fall = lhbl_l & ~LHBL`
  - `vb_fall = lvbl_l & ~LVBL`
  - `bnd = sh_mode ? vb_fall : hb_fall`. When a write is in progress, use `cpu_din[4]` instead of `sh_mode`.
- **State machine:**
  - IDLE: `pending = 0`. `cpu_we` without `bnd` → PENDING.
  - PENDING: `pending = 1`. `bnd` → load the live registers from the shadow, pulse `commit`, → IDLE. `cpu_we` without `bnd` → stay in PENDING with the new shadow value.
  - Simultaneous `cpu_we` and `bnd`, in either state: the write data goes straight to the live registers, `commit` pulses, and the next state is IDLE. The written value wins.
  - `bnd` in IDLE: no action, no `commit` pulse.
- **Watchdog:**
  - 4-bit `lcnt` increments on each `hb_fall` and saturates at `WDOG_LINES`.
  - A rising edge of `vdp_hs` (registered edge detect) clears `lcnt` and sets `vdp_ok = 1`.
  - `lcnt` reaching `WDOG_LINES` clears `vdp_ok`.
  - If a `vdp_hs` rise and an `hb_fall` occur in the same cycle, the `vdp_hs` rise wins: `lcnt = 0`, `vdp_ok = 1`.
- **Reset values:** all outputs 0, state IDLE, shadow and live registers 0, `lcnt = 0`, `lhbl_l = lvbl_l = 1`, `vdp_hs` edge register = 1. `vdp_prio` is 0 unless `debug_bus[7]` is set. A reset mid-pending discards the shadow value.

## Timing
- All registers update on `posedge clk` and reset asynchronously on `rst`.
- Boundary latency: `LHBL` falls at edge N; `hb_fall` is true during the cycle after edge N; the live registers, `commit` and IDLE all update at edge N+1.
- Write-to-live latency is at minimum the time to the next boundary. If the boundary coincides with the write, the outputs change one `clk` after the strobe.
- `pending` rises one cycle after `cpu_we` and falls together with the `commit` pulse.
- `vdp_ok` falls one cycle after the `hb_fall` that brings `lcnt` to `WDOG_LINES`.
- `vdp_ok` rises one cycle after the `vdp_hs` rise is detected, i.e. edge register plus one.
- `vdp_en` follows `vdp_ok` combinationally, with no extra cycle.

## Test plan
- **Line commit:** reset, then `cpu_we` with `cpu_din = 8'h0D` (prio 5, en, line mode). Expect `pending = 1` and `vdp_prio = 0` until the next `LHBL` fall. One cycle after that fall: `vdp_prio = 5`, one-cycle `commit`, `pending = 0`.
- **Frame mode:** write `8'h1B` (prio 3, en, frame mode). Several `LHBL` falls leave `vdp_prio` unchanged. On the `LVBL` fall, `vdp_prio = 3`.
- **Overwrite and collision:**
  - Write `8'h01`, then `8'h0E` before the boundary. The commit yields `vdp_prio = 6`.
  - Drive `cpu_we` with `8'h07` in the same cycle as `hb_fall`. Next cycle `vdp_prio = 7` and `pending` never rises.
- **Watchdog:** with `WDOG_LINES = 4`, `act_en = 1` and `vdp_hs` held low, `vdp_ok` falls after the 4th `LHBL` fall and `vdp_en = 0`. One `vdp_hs` pulse sets `vdp_ok = 1` and `vdp_en = 1`. Also check that a `vdp_hs` rise coincident with the 4th `hb_fall` keeps `vdp_ok = 1`.
- **Debug override:** with `act_prio = 2` and `debug_bus = 8'h85`, `vdp_prio = 5` immediately. Clearing bit 7 returns `vdp_prio = 2`, and `commit` does not pulse.
- **Reset mid-pending:** write `8'h0F`, assert `rst` before the boundary, release it, and apply an `LHBL` fall. Expect `vdp_prio = 0`, `pending = 0`, `commit = 0` and `vdp_ok = 0`.

Source files
------------

// File: rtl/jts18_vdp_mixctl.sv
// System 18 VDP mixer control: CPU-written priority/enable byte is held in a
// shadow register and committed to the live mixer outputs only at a line or
// frame boundary. A watchdog on the VDP hsync gates the VDP layer off when
// the VDP stops producing lines.
module jts18_vdp_mixctl #(
    parameter int WDOG_LINES = 4
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       cpu_we,
    input  logic [7:0] cpu_din,
    input  logic       LHBL,
    input  logic       LVBL,
    input  logic       vdp_hs,
    input  logic [7:0] debug_bus,
    output logic [2:0] vdp_prio,
    output logic       vdp_en,
    output logic       pending,
    output logic       commit,
    output logic       vdp_ok
);

    typedef enum logic { IDLE, PEND } state_t;

    localparam logic [3:0] WDOG = 4'(WDOG_LINES);

    state_t     st;
    logic [2:0] sh_prio, act_prio;
    logic       sh_en, sh_mode, act_en;
    logic       lhbl_l, lvbl_l, hs_l;
    logic [3:0] lcnt;
    logic       hb_fall, vb_fall, hs_rise, bnd, cur_mode;
    logic       unused_bits;

    assign hb_fall  = lhbl_l & ~LHBL;
    assign vb_fall  = lvbl_l & ~LVBL;
    assign hs_rise  = vdp_hs & ~hs_l;
    // A write in flight decides which boundary applies to itself
    assign cur_mode = cpu_we ? cpu_din[4] : sh_mode;
    assign bnd      = cur_mode ? vb_fall : hb_fall;

    assign vdp_prio    = debug_bus[7] ? debug_bus[2:0] : act_prio;
    assign vdp_en      = act_en & vdp_ok;
    assign unused_bits = ^{cpu_din[7:5], debug_bus[6:3]};

    // Delayed copies of blanking and hsync for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lhbl_l <= 1'b1;
            lvbl_l <= 1'b1;
            hs_l   <= 1'b1;
        end else begin
            lhbl_l <= LHBL;
            lvbl_l <= LVBL;
            hs_l   <= vdp_hs;
        end
    end

    // Shadow/live register control: commit only on a boundary, write wins on collision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            pending  <= 1'b0;
            commit   <= 1'b0;
            sh_prio  <= 3'd0;
            sh_en    <= 1'b0;
            sh_mode  <= 1'b0;
            act_prio <= 3'd0;
            act_en   <= 1'b0;
        end else begin
            commit <= 1'b0;
            if (cpu_we) begin
                sh_prio <= cpu_din[2:0];
                sh_en   <= cpu_din[3];
                sh_mode <= cpu_din[4];
            end
            case (st)
                IDLE: begin
                    if (cpu_we && bnd) begin
                        act_prio <= cpu_din[2:0];
                        act_en   <= cpu_din[3];
                        commit   <= 1'b1;
                    end else if (cpu_we) begin
                        st      <= PEND;
                        pending <= 1'b1;
                    end
                end
                PEND: begin
                    if (cpu_we && bnd) begin
                        act_prio <= cpu_din[2:0];
                        act_en   <= cpu_din[3];
                        commit   <= 1'b1;
                        st       <= IDLE;
                        pending  <= 1'b0;
                    end else if (bnd) begin
                        act_prio <= sh_prio;
                        act_en   <= sh_en;
                        commit   <= 1'b1;
                        st       <= IDLE;
                        pending  <= 1'b0;
                    end
                end
                default: begin
                    st      <= IDLE;
                    pending <= 1'b0;
                end
            endcase
        end
    end

    // Line watchdog: hsync rise restarts the count, saturating count drops vdp_ok
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcnt   <= 4'd0;
            vdp_ok <= 1'b0;
        end else if (hs_rise) begin
            lcnt   <= 4'd0;
            vdp_ok <= 1'b1;
        end else if (hb_fall && lcnt < WDOG) begin
            lcnt <= lcnt + 4'd1;
            if (lcnt + 4'd1 == WDOG) vdp_ok <= 1'b0;
        end
    end

endmodule
